// File: rtl/inst_mem.sv
// Instruction memory responding to fetch requests with a fixed wait-state latency.
// Flags misaligned and out-of-range fetches; a separate loader port writes program words.
module inst_mem #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [31:0]           inst_addr,
  output logic                  inst_ready,
  output logic                  inst_valid,
  output logic [31:0]           inst_rdata,
  output logic                  inst_err,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_wdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [31:0]           addr_lat;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic [31:0]           rd_addr;
  logic [31:0]           off;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  resp_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           resp_data;

  assign accept = inst_req && inst_ready;

  // Zero wait states respond on the accepting edge, so the live address is decoded.
  assign rd_addr      = (WAIT_CYCLES == 0) ? inst_addr : addr_lat;
  assign off          = rd_addr - BASE_ADDR;
  assign misaligned   = (rd_addr[1:0] != 2'b00);
  assign out_of_range = ((off >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign resp_err     = misaligned || out_of_range;
  assign idx          = off[DEPTH_LOG2+1:2];
  assign resp_data    = resp_err ? NOP_INST : mem[idx];

  // Loader write port, independent of the fetch state machine.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_wdata;
    end
  end

  // Fetch FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_lat   <= '0;
      inst_ready <= 1'b1;
      inst_valid <= 1'b0;
      inst_err   <= 1'b0;
      inst_rdata <= NOP_INST;
    end else begin
      inst_valid <= 1'b0;
      inst_ready <= 1'b1;
      unique case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            addr_lat <= inst_addr;
            if (WAIT_CYCLES == 0) begin
              state      <= S_RESP;
              inst_valid <= 1'b1;
              inst_err   <= resp_err;
              inst_rdata <= resp_data;
            end else begin
              state      <= S_WAIT;
              cnt        <= WAIT_INIT;
              inst_ready <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= S_RESP;
            inst_valid <= 1'b1;
            inst_err   <= resp_err;
            inst_rdata <= resp_data;
          end else begin
            inst_ready <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: four instances with different latencies/bases share one stimulus
// stream and are compared each cycle against an event-based reference model.
module tb_inst_mem;

  localparam int N = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic [31:0]       addr = '0;
  logic              ld_we = 1'b0;
  logic [9:0]        ld_addr = '0;
  logic [31:0]       ld_wdata = '0;

  logic [N-1:0]        ready;
  logic [N-1:0]        valid;
  logic [N-1:0]        err;
  logic [N-1:0][31:0]  rdata;

  int unsigned  wc_m   [N] = '{0, 1, 2, 3};
  logic [31:0]  base_m [N] = '{32'h0, 32'h0, 32'h1000, 32'h1000};

  // Reference model state: pending fetch with its due edge number.
  bit           pend   [N];
  longint       due    [N];
  logic [31:0]  paddr  [N];
  logic         mready [N];
  logic         mvalid [N];
  logic         merr   [N];
  logic [31:0]  mrdata [N];
  logic [31:0]  mmem   [1024];
  longint       ecount = 0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk(clk), .rst(rst), .inst_req(req), .inst_addr(addr),
    .inst_ready(ready[0]), .inst_valid(valid[0]), .inst_rdata(rdata[0]), .inst_err(err[0]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata));
  inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
    .clk(clk), .rst(rst), .inst_req(req), .inst_addr(addr),
    .inst_ready(ready[1]), .inst_valid(valid[1]), .inst_rdata(rdata[1]), .inst_err(err[1]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata));
  inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h1000)) u_w2 (
    .clk(clk), .rst(rst), .inst_req(req), .inst_addr(addr),
    .inst_ready(ready[2]), .inst_valid(valid[2]), .inst_rdata(rdata[2]), .inst_err(err[2]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata));
  inst_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000)) u_w3 (
    .clk(clk), .rst(rst), .inst_req(req), .inst_addr(addr),
    .inst_ready(ready[3]), .inst_valid(valid[3]), .inst_rdata(rdata[3]), .inst_err(err[3]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      pend[k]   = 1'b0;
      mready[k] = 1'b1;
      mvalid[k] = 1'b0;
      merr[k]   = 1'b0;
      mrdata[k] = NOP;
    end
  endtask

  task automatic model_respond(input int k);
    logic [31:0] o;
    o = paddr[k] - base_m[k];
    if ((paddr[k] % 4) != 0 || (o / 4) >= 1024) begin
      merr[k]   = 1'b1;
      mrdata[k] = NOP;
    end else begin
      merr[k]   = 1'b0;
      mrdata[k] = mmem[o / 4];
    end
  endtask

  // One rising edge of the model: accepts, due responses (old memory), then loader write.
  task automatic model_edge();
    ecount++;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        mvalid[k] = 1'b0;
        if (req && mready[k]) begin
          pend[k]  = 1'b1;
          due[k]   = ecount + longint'(wc_m[k]);
          paddr[k] = addr;
        end
        if (pend[k] && due[k] == ecount) begin
          model_respond(k);
          pend[k]   = 1'b0;
          mvalid[k] = 1'b1;
        end
        mready[k] = !pend[k];
      end
    end
    if (ld_we) mmem[ld_addr] = ld_wdata;
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("ready%0d", k), 32'(ready[k]), 32'(mready[k]));
      check($sformatf("valid%0d", k), 32'(valid[k]), 32'(mvalid[k]));
      check($sformatf("err%0d", k), 32'(err[k]), 32'(merr[k]));
      check($sformatf("rdata%0d", k), rdata[k], mrdata[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain();
    req = 1'b0;
    repeat (4) step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0: a = {20'h0, 10'($urandom), 2'b00};
      1: a = 32'h1000 + {20'h0, 10'($urandom), 2'b00};
      2: a = {19'h0, 13'($urandom)};
      3: begin
        case ($urandom_range(0, 5))
          0: a = 32'h0000_0FFC;
          1: a = 32'h0000_1000;
          2: a = 32'h0000_1FFC;
          3: a = 32'h0000_2000;
          4: a = 32'hFFFF_FFFC;
          default: a = 32'h0000_1002;
        endcase
      end
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    model_reset();
    step();
    step();
    rst = 1'b0;
    check("rst_rdata", rdata[3], NOP);
    check("rst_ready", 32'(ready[1]), 32'd1);

    // Preload every word so nothing reads uninitialised storage.
    for (int i = 0; i < 1024; i++) begin
      ld_we    = 1'b1;
      ld_addr  = 10'(i);
      ld_wdata = (i == 0) ? 32'h0050_0093 : (i == 1) ? 32'h00A0_0113 :
                 (i == 5) ? NOP : $urandom;
      step();
    end
    ld_we = 1'b0;
    drain();

    // Load then fetch with one wait state.
    req = 1'b1; addr = 32'h0;
    step();
    addr = 32'h4;
    step();
    check("lf_valid0", 32'(valid[1]), 32'd1);
    check("lf_data0", rdata[1], 32'h0050_0093);
    step();
    req = 1'b0;
    step();
    check("lf_valid1", 32'(valid[1]), 32'd1);
    check("lf_data1", rdata[1], 32'h00A0_0113);
    check("lf_err1", 32'(err[1]), 32'd0);
    drain();

    // Back-to-back with zero wait states.
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      step();
      check("b2b_valid", 32'(valid[0]), 32'd1);
      check("b2b_ready", 32'(ready[0]), 32'd1);
      check("b2b_data", rdata[0], mmem[i]);
    end
    check("b2b_word2", rdata[0], mmem[2]);
    drain();

    // Loader write to word 5 on the edge that enters RESP for instance 1.
    req = 1'b1; addr = 32'h14;
    step();
    req = 1'b0;
    ld_we = 1'b1; ld_addr = 10'd5; ld_wdata = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    check("col_old", rdata[1], NOP);
    drain();
    req = 1'b1; addr = 32'h14;
    step();
    req = 1'b0;
    step();
    check("col_new", rdata[1], 32'hDEAD_BEEF);
    drain();

    // Address errors against the 0x1000-based instance.
    begin
      logic [31:0] ea [4] = '{32'h1002, 32'h2000, 32'h0FFC, 32'h1FFC};
      logic        ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        req = 1'b1; addr = ea[i];
        step();
        req = 1'b0;
        step();
        step();
        check("er_valid", 32'(valid[2]), 32'd1);
        check("er_err", 32'(err[2]), 32'(ee[i]));
        check("er_data", rdata[2], ee[i] ? NOP : mmem[1023]);
        drain();
      end
    end

    // Requests held during WAIT are ignored until the RESP cycle.
    req = 1'b1; addr = 32'h1004;
    step();
    addr = 32'h1FFC;
    step();
    check("ign_wait_ready", 32'(ready[2]), 32'd0);
    step();
    check("ign_first", rdata[2], 32'h00A0_0113);
    step();
    req = 1'b0;
    step();
    step();
    check("ign_second_valid", 32'(valid[2]), 32'd1);
    check("ign_second", rdata[2], mmem[1023]);
    drain();

    // Asynchronous reset in the middle of a wait.
    req = 1'b1; addr = 32'h1000;
    step();
    req = 1'b0;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(valid[3]), 32'd0);
    check("arst_ready", 32'(ready[3]), 32'd1);
    check("arst_rdata", rdata[3], NOP);
    step();
    rst = 1'b0;
    repeat (6) step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      req      = ($urandom_range(0, 3) != 0);
      addr     = rand_addr();
      ld_we    = ($urandom_range(0, 3) == 0);
      ld_addr  = 10'($urandom);
      ld_wdata = $urandom;
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; req = 1'b0; ld_we = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
